// File: rtl/mem_lsu_if.sv
// Shared memory-op encodings and the LSU <-> data RAM request/ack bus.
// The package comes first so both the LSU and its environment see one set of op codes.
package mem_lsu_pkg;
  localparam logic [3:0] OP_LB  = 4'h1;
  localparam logic [3:0] OP_LH  = 4'h2;
  localparam logic [3:0] OP_LW  = 4'h3;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h6;
  localparam logic [3:0] OP_SH  = 4'h7;
  localparam logic [3:0] OP_SW  = 4'h8;
endpackage

interface mem_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int LANES = DATA_WIDTH / 8;

  logic                  req;
  logic                  we;
  logic [LANES-1:0]      be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, be, addr, wdata, input ack, rdata);
  modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: byte-enable stores, sign/zero-extended loads,
// pipeline stall while a RAM access is outstanding, misalign and timeout reporting.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RADDR_WIDTH    = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [3:0]             mem_op_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [31:0]            mem_data_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [31:0]            reg_wdata_i,
  mem_lsu_if.master              ram,
  output logic                   valid_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [31:0]            reg_wdata_o,
  output logic                   misalign_o,
  output logic                   timeout_o
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic                   we_q, we_d;
  logic [LANES-1:0]       be_q, be_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [3:0]             op_q, op_d;
  logic [OFFW-1:0]        off_q, off_d;
  logic                   lat_we_q, lat_we_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                   rwe_q, rwe_d;
  logic [31:0]            rwdata_q, rwdata_d;
  logic                   misalign_q, misalign_d;
  logic                   timeout_q, timeout_d;

  // Decode of the incoming instruction.
  logic                   is_mem, is_store, misaligned;
  logic [LANES-1:0]       be_base;
  logic [DATA_WIDTH-1:0]  wdata_rep;
  logic [OFFW-1:0]        off_in;

  assign off_in = mem_addr_i[OFFW-1:0];

  always_comb begin
    is_mem     = 1'b1;
    is_store   = 1'b0;
    misaligned = 1'b0;
    be_base    = LANES'(4'hF);
    wdata_rep  = {(LANES/4){mem_data_i}};
    unique case (mem_op_i)
      OP_LB, OP_LBU, OP_SB: begin
        be_base   = LANES'(4'h1);
        wdata_rep = {LANES{mem_data_i[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        be_base    = LANES'(4'h3);
        wdata_rep  = {(LANES/2){mem_data_i[15:0]}};
        misaligned = mem_addr_i[0];
      end
      OP_LW, OP_SW: misaligned = |mem_addr_i[1:0];
      default:      is_mem = 1'b0;
    endcase
    is_store = (mem_op_i == OP_SB) || (mem_op_i == OP_SH) || (mem_op_i == OP_SW);
  end

  // Load data: move the addressed lane down to bit 0, then extend.
  logic [31:0] rsel, load_data;
  logic        is_load_q, timeout_hit;

  assign rsel      = 32'(ram.rdata >> {off_q, 3'b000});
  assign is_load_q = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW) ||
                     (op_q == OP_LBU) || (op_q == OP_LHU);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    unique case (op_q)
      OP_LB:   load_data = {{24{rsel[7]}}, rsel[7:0]};
      OP_LH:   load_data = {{16{rsel[15]}}, rsel[15:0]};
      OP_LBU:  load_data = {24'h0, rsel[7:0]};
      OP_LHU:  load_data = {16'h0, rsel[15:0]};
      default: load_data = rsel;
    endcase
  end

  always_comb begin
    // NOTE: every signal is given a default before the case so no latch is inferred.
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    off_d      = off_q;
    lat_we_d   = lat_we_q;
    cnt_d      = cnt_q;
    waddr_d    = waddr_q;
    rwdata_d   = rwdata_q;
    valid_d    = 1'b0;
    rwe_d      = 1'b0;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      IDLE: if (valid_i) begin
        waddr_d = reg_waddr_i;
        if (!is_mem) begin
          valid_d  = 1'b1;
          rwe_d    = reg_we_i;
          rwdata_d = reg_wdata_i;
        end else if (misaligned) begin
          valid_d    = 1'b1;
          misalign_d = 1'b1;
        end else begin
          state_d  = BUSY;
          req_d    = 1'b1;
          we_d     = is_store;
          be_d     = be_base << off_in;
          addr_d   = {mem_addr_i[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
          wdata_d  = wdata_rep;
          op_d     = mem_op_i;
          off_d    = off_in;
          lat_we_d = reg_we_i;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        // An ack on the limit cycle wins over the timeout.
        if (ram.ack || timeout_hit) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          valid_d = 1'b1;
          if (!ram.ack) begin
            timeout_d = 1'b1;
          end else if (is_load_q) begin
            rwe_d    = lat_we_q;
            rwdata_d = load_data;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= '0;
      off_q      <= '0;
      lat_we_q   <= 1'b0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      waddr_q    <= '0;
      rwe_q      <= 1'b0;
      rwdata_q   <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_q       <= op_d;
      off_q      <= off_d;
      lat_we_q   <= lat_we_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      waddr_q    <= waddr_d;
      rwe_q      <= rwe_d;
      rwdata_q   <= rwdata_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign ram.req     = req_q;
  assign ram.we      = we_q;
  assign ram.be      = be_q;
  assign ram.addr    = addr_q;
  assign ram.wdata   = wdata_q;
  assign valid_o     = valid_q;
  assign reg_waddr_o = waddr_q;
  assign reg_we_o    = rwe_q;
  assign reg_wdata_o = rwdata_q;
  assign misalign_o  = misalign_q;
  assign timeout_o   = timeout_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 32-bit instance with a short timeout and a 64-bit instance.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [31:0] addr = '0, data = '0, wdata_in = '0;
  logic [4:0]  waddr_in = '0;
  logic        we_in = 1'b0;

  logic        ready_a, vo_a, we_a, mis_a, to_a;
  logic [4:0]  wa_a;
  logic [31:0] wd_a;
  logic        ready_b, vo_b, we_b, mis_b, to_b;
  logic [4:0]  wa_b;
  logic [31:0] wd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ram_a ();
  mem_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) ram_b ();

  mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RADDR_WIDTH(5), .TIMEOUT_CYCLES(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_a), .ready_o(ready_a),
    .mem_op_i(op), .mem_addr_i(addr), .mem_data_i(data),
    .reg_waddr_i(waddr_in), .reg_we_i(we_in), .reg_wdata_i(wdata_in),
    .ram(ram_a), .valid_o(vo_a), .reg_waddr_o(wa_a), .reg_we_o(we_a),
    .reg_wdata_o(wd_a), .misalign_o(mis_a), .timeout_o(to_a)
  );

  mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .RADDR_WIDTH(5), .TIMEOUT_CYCLES(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_b), .ready_o(ready_b),
    .mem_op_i(op), .mem_addr_i(addr), .mem_data_i(data),
    .reg_waddr_i(waddr_in), .reg_we_i(we_in), .reg_wdata_i(wdata_in),
    .ram(ram_b), .valid_o(vo_b), .reg_waddr_o(wa_b), .reg_we_o(we_b),
    .reg_wdata_o(wd_b), .misalign_o(mis_b), .timeout_o(to_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction to dut_a for a single accepting cycle.
  task automatic issue_a(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] wa);
    op = o; addr = a; data = d; waddr_in = wa; we_in = 1'b1; wdata_in = 32'h0;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
    checks++; if (ram_a.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", ram_a.req); end
    checks++; if (ram_a.be !== 4'h0 || ram_a.we !== 1'b0) begin errors++; $display("FAIL reset_be_we: got %h/%b expected 0/0", ram_a.be, ram_a.we); end
    checks++; if (ram_a.addr !== 32'h0 || ram_a.wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", ram_a.addr, ram_a.wdata); end
    checks++; if ({vo_a, we_a, mis_a, to_a} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {vo_a, we_a, mis_a, to_a}); end
    checks++; if (wd_a !== 32'h0 || wa_a !== 5'h0) begin errors++; $display("FAIL reset_regs: got %h/%h expected 0/0", wd_a, wa_a); end
  endtask

  task automatic test_load_byte(input logic [3:0] o, input logic [31:0] exp);
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL lb_ready_pre: got %b expected 1", ready_a); end
    issue_a(o, 32'h0000_1003, 32'h0, 5'd3);
    checks++; if (ram_a.req !== 1'b1 || ram_a.we !== 1'b0) begin errors++; $display("FAIL lb_req: got req=%b we=%b expected 1/0", ram_a.req, ram_a.we); end
    checks++; if (ram_a.addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h expected 00001000", ram_a.addr); end
    checks++; if (ram_a.be !== 4'h8) begin errors++; $display("FAIL lb_be: got %h expected 8", ram_a.be); end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin ram_a.ack = 1'b1; ram_a.rdata = 32'h8012_3456; end
      checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL lb_stall_%0d: got ready %b expected 0", i, ready_a); end
      tick();
    end
    ram_a.ack = 1'b0;
    checks++; if (vo_a !== 1'b1 || we_a !== 1'b1 || wa_a !== 5'd3) begin errors++; $display("FAIL lb_wb: got v=%b we=%b wa=%0d expected 1/1/3", vo_a, we_a, wa_a); end
    checks++; if (wd_a !== exp) begin errors++; $display("FAIL lb_data: got %h expected %h", wd_a, exp); end
    checks++; if (ram_a.req !== 1'b0 || ready_a !== 1'b1) begin errors++; $display("FAIL lb_done: got req=%b ready=%b expected 0/1", ram_a.req, ready_a); end
    tick();
    checks++; if (vo_a !== 1'b0 || we_a !== 1'b0) begin errors++; $display("FAIL lb_pulse: got v=%b we=%b expected 0/0", vo_a, we_a); end
  endtask

  task automatic test_store_half();
    issue_a(OP_SH, 32'h0000_2002, 32'h0000_BEEF, 5'd4);
    checks++; if (ram_a.req !== 1'b1 || ram_a.we !== 1'b1) begin errors++; $display("FAIL sh_req: got req=%b we=%b expected 1/1", ram_a.req, ram_a.we); end
    checks++; if (ram_a.be !== 4'hC || ram_a.addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_be_addr: got %h/%h expected c/00002000", ram_a.be, ram_a.addr); end
    checks++; if (ram_a.wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h expected beefbeef", ram_a.wdata); end
    ram_a.ack = 1'b1;
    tick();
    ram_a.ack = 1'b0;
    checks++; if (vo_a !== 1'b1 || we_a !== 1'b0) begin errors++; $display("FAIL sh_done: got v=%b we=%b expected 1/0", vo_a, we_a); end
  endtask

  task automatic test_misalign();
    issue_a(OP_LW, 32'h0000_1002, 32'h0, 5'd8);
    checks++; if (vo_a !== 1'b1 || mis_a !== 1'b1 || we_a !== 1'b0) begin errors++; $display("FAIL mis_pulse: got v=%b mis=%b we=%b expected 1/1/0", vo_a, mis_a, we_a); end
    checks++; if (ram_a.req !== 1'b0 || ready_a !== 1'b1) begin errors++; $display("FAIL mis_noreq: got req=%b ready=%b expected 0/1", ram_a.req, ready_a); end
    tick();
    checks++; if (ram_a.req !== 1'b0 || mis_a !== 1'b0 || vo_a !== 1'b0) begin errors++; $display("FAIL mis_after: got req=%b mis=%b v=%b expected 0/0/0", ram_a.req, mis_a, vo_a); end
  endtask

  task automatic test_timeout();
    issue_a(OP_LW, 32'h0000_3000, 32'h0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      checks++; if (ram_a.req !== 1'b1 || vo_a !== 1'b0) begin errors++; $display("FAIL to_wait_%0d: got req=%b v=%b expected 1/0", i, ram_a.req, vo_a); end
      tick();
    end
    checks++; if (vo_a !== 1'b1 || to_a !== 1'b1 || we_a !== 1'b0) begin errors++; $display("FAIL to_pulse: got v=%b to=%b we=%b expected 1/1/0", vo_a, to_a, we_a); end
    checks++; if (ram_a.req !== 1'b0 || ready_a !== 1'b1) begin errors++; $display("FAIL to_release: got req=%b ready=%b expected 0/1", ram_a.req, ready_a); end
    tick();
    // Ack arriving exactly on the limit cycle completes normally.
    issue_a(OP_LW, 32'h0000_3004, 32'h0, 5'd10);
    tick(); tick(); tick();
    ram_a.ack = 1'b1; ram_a.rdata = 32'hCAFE_F00D;
    tick();
    ram_a.ack = 1'b0;
    checks++; if (vo_a !== 1'b1 || to_a !== 1'b0 || we_a !== 1'b1) begin errors++; $display("FAIL to_edge_ack: got v=%b to=%b we=%b expected 1/0/1", vo_a, to_a, we_a); end
    checks++; if (wd_a !== 32'hCAFE_F00D) begin errors++; $display("FAIL to_edge_data: got %h expected cafef00d", wd_a); end
    tick();
  endtask

  task automatic test_back_to_back();
    op = 4'h0; we_in = 1'b1; valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waddr_in = 5'(5 + i);
      wdata_in = 32'h100 + 32'(i);
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, ready_a); end
      tick();
      checks++; if (vo_a !== 1'b1 || we_a !== 1'b1 || wa_a !== 5'(5 + i) || wd_a !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL b2b_out_%0d: got v=%b we=%b wa=%0d wd=%h expected 1/1/%0d/%h", i, vo_a, we_a, wa_a, wd_a, 5 + i, 32'h100 + 32'(i));
      end
    end
    valid_a = 1'b0;
    tick();
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL b2b_end: got v=%b expected 0", vo_a); end
  endtask

  task automatic test_reset_busy();
    issue_a(OP_LW, 32'h0000_1000, 32'h0, 5'd11);
    checks++; if (ram_a.req !== 1'b1) begin errors++; $display("FAIL rb_req: got %b expected 1", ram_a.req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ram_a.req !== 1'b0 || vo_a !== 1'b0 || ready_a !== 1'b1) begin errors++; $display("FAIL rb_reset: got req=%b v=%b ready=%b expected 0/0/1", ram_a.req, vo_a, ready_a); end
    ram_a.ack = 1'b1; ram_a.rdata = 32'h1234_5678;
    tick();
    ram_a.ack = 1'b0;
    checks++; if (vo_a !== 1'b0 || we_a !== 1'b0) begin errors++; $display("FAIL rb_late_ack: got v=%b we=%b expected 0/0", vo_a, we_a); end
  endtask

  task automatic test_wide_half();
    op = OP_LH; addr = 32'h0000_0106; waddr_in = 5'd12; we_in = 1'b1; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    checks++; if (ram_b.addr !== 32'h0000_0100 || ram_b.be !== 8'hC0) begin errors++; $display("FAIL w64_req: got addr=%h be=%h expected 00000100/c0", ram_b.addr, ram_b.be); end
    ram_b.ack = 1'b1; ram_b.rdata = 64'h8001_0000_0000_0000;
    tick();
    ram_b.ack = 1'b0;
    checks++; if (vo_b !== 1'b1 || we_b !== 1'b1 || wd_b !== 32'hFFFF_8001) begin errors++; $display("FAIL w64_load: got v=%b we=%b wd=%h expected 1/1/ffff8001", vo_b, we_b, wd_b); end
    // Byte store on the wide bus: replicated data, single strobe at lane 5.
    op = OP_SB; addr = 32'h0000_0205; data = 32'h0000_00A5; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    checks++; if (ram_b.be !== 8'h20 || ram_b.wdata !== 64'hA5A5_A5A5_A5A5_A5A5 || ram_b.addr !== 32'h0000_0200) begin
      errors++; $display("FAIL w64_sb: got be=%h wdata=%h addr=%h expected 20/a5a5a5a5a5a5a5a5/00000200", ram_b.be, ram_b.wdata, ram_b.addr);
    end
    ram_b.ack = 1'b1;
    tick();
    ram_b.ack = 1'b0;
    checks++; if (vo_b !== 1'b1 || we_b !== 1'b0) begin errors++; $display("FAIL w64_sb_done: got v=%b we=%b expected 1/0", vo_b, we_b); end
  endtask

  initial begin
    ram_a.ack = 1'b0; ram_a.rdata = '0;
    ram_b.ack = 1'b0; ram_b.rdata = '0;
    test_reset();
    test_load_byte(OP_LB, 32'hFFFF_FF80);
    test_load_byte(OP_LBU, 32'h0000_0080);
    test_store_half();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    test_wide_half();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Parametrised load/store unit for the MEM stage. It sits between exe_mem and mem_wb and talks to data RAM through a req/ack handshake with per-byte write strobes. It supports multi-cycle RAM latency, stalls the pipeline while an access is in flight, detects misaligned accesses and detects RAM timeouts. Stores use byte enables, so sub-word stores need no read-modify-write.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, RAM data width. Legal values are 32 and 64. LANES = DATA_WIDTH/8; OFFW = log2(LANES).
RADDR_WIDTH, 5, register-file address width.
TIMEOUT_CYCLES, 16, maximum cycles to wait for ram_ack_i. 0 disables the timeout.

Ports:
clk_i  in  1  clock; everything is on the rising edge
rst_i  in  1  synchronous reset, active-high
valid_i  in  1  exe_mem presents an instruction
ready_o  out  1  the LSU accepts this cycle; 0 = stall upstream
mem_op_i  in  4  LB/LH/LW/LBU/LHU/SB/SH/SW per the shared op defines; any other code = no memory access
mem_addr_i  in  ADDR_WIDTH  byte address
mem_data_i  in  32  store data, LSB-aligned
reg_waddr_i  in  RADDR_WIDTH  destination register
reg_we_i  in  1  register write enable
reg_wdata_i  in  32  ALU result for non-memory ops
ram_req_o  out  1  RAM request
ram_we_o  out  1  1 = write
ram_be_o  out  LANES  byte enables
ram_addr_o  out  ADDR_WIDTH  lane-aligned address (low OFFW bits are 0)
ram_wdata_o  out  DATA_WIDTH  store data, replicated across lanes
ram_ack_i  in  1  RAM completes the request; ram_rdata_i is valid in this cycle
ram_rdata_i  in  DATA_WIDTH  read data
valid_o  out  1  one-cycle pulse to mem_wb
reg_waddr_o  out  RADDR_WIDTH  destination register
reg_we_o  out  1  write enable; forced to 0 whenever valid_o is 0
reg_wdata_o  out  32  write-back data
misalign_o  out  1  one-cycle pulse together with valid_o
timeout_o  out  1  one-cycle pulse together with valid_o

Behaviour:
- Reset: state=IDLE. ram_req_o, ram_we_o, ram_be_o, valid_o, reg_we_o, misalign_o, timeout_o are 0. ram_addr_o, ram_wdata_o, reg_waddr_o, reg_wdata_o are 0. The timeout counter is 0. Reset mid-BUSY drops ram_req_o on the next edge and produces no valid_o.
- FSM states: IDLE, BUSY.
- ready_o = (state==IDLE), combinational. An instruction is accepted when valid_i && ready_o.
- IDLE, accepted non-memory op: on the next edge, valid_o=1 and reg_* = reg_*_i. Latency is 1 cycle; back-to-back ops give a throughput of 1 per cycle.
- IDLE, accepted memory op, misaligned: an access is misaligned when
  - LH/LHU/SH has addr[0]!=0, or
  - LW/SW has addr[1:0]!=0.
  On the next edge: valid_o=1, misalign_o=1, reg_we_o=0. No RAM request is made and the state stays IDLE.
- IDLE, accepted aligned memory op: on the next edge, move to BUSY and register the request.
  - ram_req_o=1; ram_we_o=1 for SB/SH/SW.
  - ram_addr_o = addr with the low OFFW bits cleared.
  - off = addr[OFFW-1:0].
  - ram_be_o = (SB: 1, SH: 3, SW: 0xF) << off.
  - ram_wdata_o = mem_data_i[7:0], [15:0] or [31:0] replicated to fill DATA_WIDTH.
  - Latch the op, off and reg_waddr_i/reg_we_i.
- BUSY: the request outputs are held stable until ack. On a cycle with ram_ack_i=1, at the next edge:
  - ram_req_o=0, valid_o=1, state=IDLE.
  - Loads: select byte/half/word at bit offset off*8 of ram_rdata_i, then sign-extend (LB/LH) or zero-extend (LBU/LHU) to 32 bits. reg_we_o = latched reg_we.
  - Stores: reg_we_o=0.
- Timeout: the counter increments each BUSY cycle without ack. When it reaches TIMEOUT_CYCLES: drop ram_req_o, pulse valid_o=1 with timeout_o=1 and reg_we_o=0, return to IDLE. An ack in the same cycle as the limit takes priority, and the access completes normally. The counter clears on entry to BUSY.
- ram_ack_i is ignored while ram_req_o=0.
- valid_i is ignored in BUSY; upstream must hold its inputs while ready_o=0.

Test Plan:
- Aligned LB at addr 0x1003, ack 2 cycles after req, rdata 0x80123456 (DATA_WIDTH=32).
  -> ram_addr_o=0x1000, ram_be_o=0x8, ready_o=0 for 3 cycles, then valid_o with reg_wdata_o=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH at 0x2002 with data 0x0000BEEF.
  -> ram_we_o=1, ram_be_o=0xC, ram_wdata_o=0xBEEFBEEF; after ack, valid_o=1 and reg_we_o=0.
- LW at 0x1002.
  -> misalign_o=1, valid_o=1, reg_we_o=0, ram_req_o never asserted, ready_o stays 1.
- TIMEOUT_CYCLES=4 and ram_ack_i held 0.
  -> ram_req_o high for 4 cycles, then timeout_o=1 and valid_o=1. Also drive ack exactly at cycle 4 -> normal completion with timeout_o=0.
- Three back-to-back non-memory ops (x5, x6, x7).
  -> valid_o high for 3 consecutive cycles with matching reg_waddr_o; ready_o stays 1.
- rst_i asserted during BUSY, then ack arrives after reset.
  -> ram_req_o=0 and valid_o=0 after the reset edge; the late ack is ignored.
- DATA_WIDTH=64, LH at 0x106, rdata 0x8001_0000_0000_0000.
  -> ram_addr_o=0x100, ram_be_o=0xC0, reg_wdata_o=0xFFFF8001.
